// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: datapath widths, ALU opcodes and the
// bit layout of the registered control bundle.
package id_ex_stage_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int ALU_OPR_LEN = 4;
    localparam int CNT_W       = 16;

    localparam int REG_RA = 31;

    localparam logic [ALU_OPR_LEN-1:0] ALU_NO_OPERATION = 4'hF;
    localparam logic [ALU_OPR_LEN-1:0] ALU_ADD          = 4'h2;
    localparam logic [ALU_OPR_LEN-1:0] ALU_SUB          = 4'h6;

    // Control bundle layout: single-bit flags first, ALU opcode in the top field.
    localparam int CTRL_VALID      = 0;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_IS_EQ      = 6;
    localparam int CTRL_JAL        = 7;
    localparam int CTRL_ALU_OP_LSB = 8;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle plus pipeline control handshake of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic                  id_reg_write, id_mem_to_reg, id_mem_write, id_reg_dst;
    logic                  id_alu_src, id_branch, id_is_eq, id_jal;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0]     id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic                  hold_i, flush_i, stall_o;
    logic                  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic                  ex_alu_src, ex_branch, ex_is_eq, ex_jal;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_dst;
    logic [DATA_W-1:0]     ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output id_valid, id_reg_write, id_mem_to_reg, id_mem_write, id_reg_dst,
               id_alu_src, id_branch, id_is_eq, id_jal, id_alu_op,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc_plus4,
               hold_i, flush_i,
        input  stall_o, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write,
               ex_alu_src, ex_branch, ex_is_eq, ex_jal, ex_alu_op,
               ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4,
               bubble_cnt
    );

    modport slave (
        input  id_valid, id_reg_write, id_mem_to_reg, id_mem_write, id_reg_dst,
               id_alu_src, id_branch, id_is_eq, id_jal, id_alu_op,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc_plus4,
               hold_i, flush_i,
        output stall_o, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write,
               ex_alu_src, ex_branch, ex_is_eq, ex_jal, ex_alu_op,
               ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4,
               bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_pipe_reg.sv
// Pipeline register bank with enable and synchronous clear; reset and clear
// both load RST_VAL so a cleared bundle is identical to the reset bundle.
module pipe_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= clr ? RST_VAL : d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers the decode bundle into EX, detects load-use
// hazards, squashes on flush and counts inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = id_ex_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = id_ex_stage_pkg::REG_ADDR_W,
    parameter int ALU_OP_W   = ALU_OPR_LEN,
    parameter int CNT_W      = id_ex_stage_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    localparam int CTRL_W = CTRL_ALU_OP_LSB + ALU_OP_W;
    localparam int DBUS_W = 3 * REG_ADDR_W + 4 * DATA_W;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE =
        {ALU_OP_W'(ALU_NO_OPERATION), {CTRL_ALU_OP_LSB{1'b0}}};

    logic                  uses_rt, lu, bubble, kill_ctrl, en;
    logic [REG_ADDR_W-1:0] id_dst;
    logic [CTRL_W-1:0]     ctrl_d, ctrl_q;
    logic [DBUS_W-1:0]     data_d, data_q;
    logic [CNT_W-1:0]      bubble_cnt_reg;

    always_comb begin
        uses_rt = bus.id_reg_dst | bus.id_mem_write | bus.id_branch;
        if (bus.id_jal) begin
            id_dst = REG_ADDR_W'(REG_RA);
        end else if (bus.id_reg_dst) begin
            id_dst = bus.id_rd;
        end else begin
            id_dst = bus.id_rt;
        end
        // Hazard only against a load whose result lands in a real register.
        lu = bus.ex_valid & bus.ex_mem_to_reg & bus.ex_reg_write
           & (bus.ex_dst != '0) & bus.id_valid
           & ((bus.ex_dst == bus.id_rs) | (uses_rt & (bus.ex_dst == bus.id_rt)));
    end

    assign bus.stall_o = lu & ~bus.flush_i;
    assign bubble      = bus.flush_i | lu;
    assign kill_ctrl   = bubble | ~bus.id_valid;
    assign en          = ~bus.hold_i;

    always_comb begin
        ctrl_d                                 = '0;
        ctrl_d[CTRL_VALID]                     = bus.id_valid;
        ctrl_d[CTRL_REG_WRITE]                 = bus.id_reg_write;
        ctrl_d[CTRL_MEM_TO_REG]                = bus.id_mem_to_reg;
        ctrl_d[CTRL_MEM_WRITE]                 = bus.id_mem_write;
        ctrl_d[CTRL_ALU_SRC]                   = bus.id_alu_src;
        ctrl_d[CTRL_BRANCH]                    = bus.id_branch;
        ctrl_d[CTRL_IS_EQ]                     = bus.id_is_eq;
        ctrl_d[CTRL_JAL]                       = bus.id_jal;
        ctrl_d[CTRL_ALU_OP_LSB +: ALU_OP_W]    = bus.id_alu_op;
    end

    assign data_d = {bus.id_rs, bus.id_rt, id_dst, bus.id_rs_data,
                     bus.id_rt_data, bus.id_imm, bus.id_pc_plus4};

    // An invalid decode slot keeps its data but never carries live controls.
    pipe_reg #(.W(CTRL_W), .RST_VAL(CTRL_BUBBLE)) u_ctrl_reg (
        .clk(clk), .rst(rst), .en(en), .clr(kill_ctrl), .d(ctrl_d), .q(ctrl_q)
    );

    pipe_reg #(.W(DBUS_W), .RST_VAL('0)) u_data_reg (
        .clk(clk), .rst(rst), .en(en), .clr(bubble), .d(data_d), .q(data_q)
    );

    assign bus.ex_valid      = ctrl_q[CTRL_VALID];
    assign bus.ex_reg_write  = ctrl_q[CTRL_REG_WRITE];
    assign bus.ex_mem_to_reg = ctrl_q[CTRL_MEM_TO_REG];
    assign bus.ex_mem_write  = ctrl_q[CTRL_MEM_WRITE];
    assign bus.ex_alu_src    = ctrl_q[CTRL_ALU_SRC];
    assign bus.ex_branch     = ctrl_q[CTRL_BRANCH];
    assign bus.ex_is_eq      = ctrl_q[CTRL_IS_EQ];
    assign bus.ex_jal        = ctrl_q[CTRL_JAL];
    assign bus.ex_alu_op     = ctrl_q[CTRL_ALU_OP_LSB +: ALU_OP_W];
    assign {bus.ex_rs, bus.ex_rt, bus.ex_dst, bus.ex_rs_data,
            bus.ex_rt_data, bus.ex_imm, bus.ex_pc_plus4} = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_reg <= '0;
        end else if (en && bubble && (bubble_cnt_reg != '1)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: normal flow, load-use, flush, jal,
// hold, counter saturation and reset during hold.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic rw, input logic m2r, input logic mw,
                          input logic rdst, input logic asrc, input logic br, input logic jal,
                          input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm);
        bus.id_valid      = v;
        bus.id_reg_write  = rw;
        bus.id_mem_to_reg = m2r;
        bus.id_mem_write  = mw;
        bus.id_reg_dst    = rdst;
        bus.id_alu_src    = asrc;
        bus.id_branch     = br;
        bus.id_is_eq      = 1'b0;
        bus.id_jal        = jal;
        bus.id_alu_op     = op;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.id_imm        = imm;
    endtask

    task automatic load_lw8();
        set_id(1, 1, 1, 0, 0, 1, 0, 0, ALU_ADD, 5'd9, 5'd8, 5'd0, 32'd4);
        step();
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        bus.id_rs_data  = 32'h0;
        bus.id_rt_data  = 32'h0;
        bus.id_pc_plus4 = 32'h0;
        bus.hold_i      = 1'b0;
        bus.flush_i     = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_alu_op", bus.ex_alu_op, ALU_NO_OPERATION);
        chk("rst_dst", bus.ex_dst, 0);
        chk("rst_cnt", bus.bubble_cnt, 0);
        chk("rst_stall", bus.stall_o, 0);

        // addi $8,$0,5
        set_id(1, 1, 0, 0, 0, 1, 0, 0, ALU_ADD, 5'd0, 5'd8, 5'd0, 32'd5);
        step();
        chk("addi_dst", bus.ex_dst, 8);
        chk("addi_imm", bus.ex_imm, 5);
        chk("addi_valid", bus.ex_valid, 1);
        chk("addi_op", bus.ex_alu_op, ALU_ADD);
        chk("addi_stall", bus.stall_o, 0);

        // lw $8 then add $9,$8,$10
        load_lw8();
        set_id(1, 1, 0, 0, 1, 0, 0, 0, ALU_ADD, 5'd8, 5'd10, 5'd9, 32'd0);
        bus.id_rs_data = 32'h11;
        bus.id_rt_data = 32'h22;
        #1;
        chk("lu_stall", bus.stall_o, 1);
        step();
        exp_cnt++;
        chk("lu_bub_valid", bus.ex_valid, 0);
        chk("lu_bub_rw", bus.ex_reg_write, 0);
        chk("lu_bub_op", bus.ex_alu_op, ALU_NO_OPERATION);
        chk("lu_bub_dst", bus.ex_dst, 0);
        chk("lu_cnt", bus.bubble_cnt, exp_cnt);
        chk("lu_stall_gone", bus.stall_o, 0);
        step();
        chk("lu_add_valid", bus.ex_valid, 1);
        chk("lu_add_dst", bus.ex_dst, 9);
        chk("lu_add_rsdata", bus.ex_rs_data, 32'h11);
        chk("lu_add_cnt", bus.bubble_cnt, exp_cnt);

        // addi with rt==8 does not read rt
        load_lw8();
        set_id(1, 1, 0, 0, 0, 1, 0, 0, ALU_ADD, 5'd10, 5'd8, 5'd0, 32'd1);
        #1;
        chk("nohz_rt_stall", bus.stall_o, 0);
        step();
        chk("nohz_valid", bus.ex_valid, 1);
        chk("nohz_cnt", bus.bubble_cnt, exp_cnt);

        // sw $8 reads rt
        load_lw8();
        set_id(1, 0, 0, 1, 0, 1, 0, 0, ALU_ADD, 5'd10, 5'd8, 5'd0, 32'd0);
        #1;
        chk("sw_stall", bus.stall_o, 1);
        step();
        exp_cnt++;
        chk("sw_cnt", bus.bubble_cnt, exp_cnt);
        step();
        chk("sw_memw", bus.ex_mem_write, 1);

        // lw $0 never hazards
        set_id(1, 1, 1, 0, 0, 1, 0, 0, ALU_ADD, 5'd9, 5'd0, 5'd0, 32'd0);
        step();
        set_id(1, 1, 0, 0, 1, 0, 0, 0, ALU_ADD, 5'd0, 5'd0, 5'd9, 32'd0);
        #1;
        chk("lw0_stall", bus.stall_o, 0);

        // flush with simultaneous load-use
        load_lw8();
        set_id(1, 1, 0, 0, 1, 0, 0, 0, ALU_ADD, 5'd8, 5'd10, 5'd9, 32'd0);
        bus.flush_i = 1'b1;
        #1;
        chk("flu_stall", bus.stall_o, 0);
        step();
        exp_cnt++;
        bus.flush_i = 1'b0;
        chk("flu_valid", bus.ex_valid, 0);
        chk("flu_rw", bus.ex_reg_write, 0);
        chk("flu_cnt", bus.bubble_cnt, exp_cnt);

        // jal
        set_id(1, 1, 0, 0, 0, 0, 0, 1, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0);
        bus.id_pc_plus4 = 32'h0040_0010;
        step();
        chk("jal_dst", bus.ex_dst, 31);
        chk("jal_flag", bus.ex_jal, 1);
        chk("jal_pc4", bus.ex_pc_plus4, 32'h0040_0010);

        // invalid slot: data captured, controls dead, no count
        set_id(0, 1, 0, 0, 0, 1, 0, 0, ALU_SUB, 5'd0, 5'd5, 5'd0, 32'h77);
        step();
        chk("inv_valid", bus.ex_valid, 0);
        chk("inv_rw", bus.ex_reg_write, 0);
        chk("inv_op", bus.ex_alu_op, ALU_NO_OPERATION);
        chk("inv_imm", bus.ex_imm, 32'h77);
        chk("inv_cnt", bus.bubble_cnt, exp_cnt);

        // hold with load-use pending
        load_lw8();
        set_id(1, 1, 0, 0, 1, 0, 0, 0, ALU_ADD, 5'd8, 5'd10, 5'd9, 32'h99);
        bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_stall", bus.stall_o, 1);
            chk("hold_m2r", bus.ex_mem_to_reg, 1);
            chk("hold_imm", bus.ex_imm, 4);
            chk("hold_cnt", bus.bubble_cnt, exp_cnt);
        end
        bus.hold_i = 1'b0;
        step();
        exp_cnt++;
        chk("unhold_bub", bus.ex_valid, 0);
        chk("unhold_cnt", bus.bubble_cnt, exp_cnt);
        step();
        chk("unhold_add", bus.ex_imm, 32'h99);

        // saturation
        bus.flush_i = 1'b1;
        for (int i = exp_cnt; i < 65535; i++) step();
        chk("sat_reach", bus.bubble_cnt, 16'hFFFF);
        step();
        chk("sat_hold", bus.bubble_cnt, 16'hFFFF);
        bus.flush_i = 1'b0;

        // reset while held with a stall pending
        load_lw8();
        set_id(1, 1, 0, 0, 1, 0, 0, 0, ALU_ADD, 5'd8, 5'd10, 5'd9, 32'd0);
        bus.hold_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rsth_valid", bus.ex_valid, 0);
        chk("rsth_dst", bus.ex_dst, 0);
        chk("rsth_op", bus.ex_alu_op, ALU_NO_OPERATION);
        chk("rsth_cnt", bus.bubble_cnt, 0);
        chk("rsth_stall", bus.stall_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
